rr_decoder_arbiter: RTL and testbench

- Four-requester round-robin arbiter that shares one downstream resource selected through the 2-to-4 decoder.
- Produces a registered 2-bit grant index that drives the decoder select inputs, plus a matching one-hot grant.
- Enforces a maximum hold time and a one-cycle dead gap between owners, so two decoder outputs are never active in the same cycle.

---
 rtl/rr_decoder_arbiter_if.sv | 25 ++
 rtl/rr_decoder_arbiter.sv | 108 ++++++++++
 tb/tb_rr_decoder_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/rr_decoder_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// The arbiter drives the shared decoder select through grant_idx.
interface rr_decoder_arbiter_if;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       expired;

  modport master (
    output req,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  expired
  );

  modport slave (
    input  req,
    output grant,
    output grant_idx,
    output grant_valid,
    output expired
  );
endinterface

// File: rtl/rr_decoder_arbiter.sv
// Four-way round-robin arbiter with a hold limit and a one-cycle dead gap
// between owners, so the downstream 2-to-4 decoder never has two outputs active.
module rr_decoder_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  rr_decoder_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t              state, state_nxt;
  logic [1:0]          grant_idx, grant_idx_nxt;
  logic [1:0]          last_idx, last_idx_nxt;
  logic [3:0]          grant, grant_nxt;
  logic                grant_valid, grant_valid_nxt;
  logic                expired, expired_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
  logic [1:0]          arb_idx;
  logic                arb_found;

  function automatic logic [3:0] decode(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Scan starting just after the previous owner so it ends up lowest priority.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = last_idx;
    for (int k = 1; k <= 4; k++) begin
      if (!arb_found && bus.req[last_idx + 2'(k)]) begin
        arb_found = 1'b1;
        arb_idx   = last_idx + 2'(k);
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    grant_idx_nxt   = grant_idx;
    last_idx_nxt    = last_idx;
    grant_nxt       = grant;
    grant_valid_nxt = grant_valid;
    expired_nxt     = 1'b0;
    hold_cnt_nxt    = hold_cnt;
    case (state)
      IDLE, GAP: begin
        if (arb_found) begin
          state_nxt       = GRANT;
          grant_idx_nxt   = arb_idx;
          grant_nxt       = decode(arb_idx);
          grant_valid_nxt = 1'b1;
          hold_cnt_nxt    = HOLD_W'(1);
        end else begin
          state_nxt       = IDLE;
          grant_nxt       = 4'b0000;
          grant_valid_nxt = 1'b0;
        end
      end
      GRANT: begin
        // A voluntary release takes precedence over the hold limit.
        if (!bus.req[grant_idx] || hold_cnt == HOLD_W'(MAX_HOLD)) begin
          state_nxt       = GAP;
          grant_nxt       = 4'b0000;
          grant_valid_nxt = 1'b0;
          last_idx_nxt    = grant_idx;
          hold_cnt_nxt    = '0;
          expired_nxt     = bus.req[grant_idx];
        end else begin
          hold_cnt_nxt    = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_nxt       = IDLE;
        grant_nxt       = 4'b0000;
        grant_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant_idx   <= 2'd0;
      last_idx    <= 2'd3;
      grant       <= 4'b0000;
      grant_valid <= 1'b0;
      expired     <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      grant_idx   <= grant_idx_nxt;
      last_idx    <= last_idx_nxt;
      grant       <= grant_nxt;
      grant_valid <= grant_valid_nxt;
      expired     <= expired_nxt;
      hold_cnt    <= hold_cnt_nxt;
    end
  end

  assign bus.grant       = grant;
  assign bus.grant_idx   = grant_idx;
  assign bus.grant_valid = grant_valid;
  assign bus.expired     = expired;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed and random checks of rr_decoder_arbiter with MAX_HOLD=8 and MAX_HOLD=1.
module tb_rr_decoder_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_decoder_arbiter_if bus8();
  rr_decoder_arbiter_if bus1();

  rr_decoder_arbiter #(.MAX_HOLD(8), .HOLD_W(4)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  rr_decoder_arbiter #(.MAX_HOLD(1), .HOLD_W(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int         tests_run    = 0;
  int         tests_failed = 0;
  bit         mon_on       = 1'b0;
  logic [3:0] prev8        = 4'b0000;
  logic [3:0] prev1        = 4'b0000;
  int         run8         = 0;
  int         run1         = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r8, input logic [3:0] r1);
    bus8.req = r8;
    bus1.req = r1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(4'b0000, 4'b0000);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check8(input string tag, input logic [3:0] g, input logic [1:0] idx,
                        input logic v, input logic e);
    checkOutput({tag, ".grant"},   bus8.grant,       g);
    checkOutput({tag, ".idx"},     bus8.grant_idx,   idx);
    checkOutput({tag, ".valid"},   bus8.grant_valid, v);
    checkOutput({tag, ".expired"}, bus8.expired,     e);
  endtask

  // Structural invariants and hold limits, sampled mid-cycle on both instances.
  always @(negedge clk) begin
    if (mon_on) begin
      checkOutput("onehot8", $onehot0(bus8.grant), 1);
      checkOutput("onehot1", $onehot0(bus1.grant), 1);
      if (bus8.grant_valid) checkOutput("decode8", bus8.grant, 4'b0001 << bus8.grant_idx);
      if (bus1.grant_valid) checkOutput("decode1", bus1.grant, 4'b0001 << bus1.grant_idx);
      checkOutput("valid8", bus8.grant_valid, bus8.grant != 4'b0000);
      checkOutput("valid1", bus1.grant_valid, bus1.grant != 4'b0000);
      checkOutput("expvalid8", bus8.expired & bus8.grant_valid, 0);
      checkOutput("expvalid1", bus1.expired & bus1.grant_valid, 0);
      checkOutput("handover8", (prev8 != 0 && bus8.grant != 0 && prev8 != bus8.grant), 0);
      checkOutput("handover1", (prev1 != 0 && bus1.grant != 0 && prev1 != bus1.grant), 0);
      run8 = (bus8.grant == 0) ? 0 : ((bus8.grant == prev8) ? run8 + 1 : 1);
      run1 = (bus1.grant == 0) ? 0 : ((bus1.grant == prev1) ? run1 + 1 : 1);
      checkOutput("maxhold8", run8 <= 8, 1);
      checkOutput("maxhold1", run1 <= 1, 1);
      prev8 = bus8.grant;
      prev1 = bus1.grant;
    end
  end

  initial begin
    int         wait_cnt [4];
    logic [3:0] nreq;
    logic [1:0] order [5];

    applyStimulus(4'b0000, 4'b0000);
    doReset();
    mon_on = 1'b1;
    check8("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    checkOutput("reset1.grant", bus1.grant, 0);
    checkOutput("reset1.expired", bus1.expired, 0);

    // Single requester 2 holds three cycles, then releases.
    applyStimulus(4'b0100, 4'b0000);
    for (int c = 0; c < 3; c++) begin
      tick();
      check8($sformatf("single.c%0d", c), 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    applyStimulus(4'b0000, 4'b0000);
    tick();
    check8("single.gap", 4'b0000, 2'd2, 1'b0, 1'b0);
    tick();
    check8("single.idle", 4'b0000, 2'd2, 1'b0, 1'b0);

    // All four request continuously: 8-cycle grants, expired gap between owners.
    doReset();
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
    applyStimulus(4'b1111, 4'b0000);
    tick();
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 8; c++) begin
        check8($sformatf("rr.o%0d.c%0d", k, c), 4'b0001 << order[k], order[k], 1'b1, 1'b0);
        tick();
      end
      check8($sformatf("rr.gap%0d", k), 4'b0000, order[k], 1'b0, 1'b1);
      tick();
    end

    // Release on exactly the last allowed cycle is voluntary, not expired.
    doReset();
    applyStimulus(4'b0001, 4'b0000);
    for (int c = 0; c < 8; c++) tick();
    check8("edge.held8", 4'b0001, 2'd0, 1'b1, 1'b0);
    applyStimulus(4'b0000, 4'b0000);
    tick();
    check8("edge.release", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Owner 1 drops while 3 waits; 0 arrives during the gap and goes after 3.
    doReset();
    applyStimulus(4'b0010, 4'b0000);
    tick();
    check8("pre.c1", 4'b0010, 2'd1, 1'b1, 1'b0);
    applyStimulus(4'b1010, 4'b0000);
    tick();
    tick();
    tick();
    check8("pre.c4", 4'b0010, 2'd1, 1'b1, 1'b0);
    applyStimulus(4'b1000, 4'b0000);
    tick();
    check8("pre.gap", 4'b0000, 2'd1, 1'b0, 1'b0);
    applyStimulus(4'b1001, 4'b0000);
    tick();
    check8("pre.owner3", 4'b1000, 2'd3, 1'b1, 1'b0);
    applyStimulus(4'b0001, 4'b0000);
    tick();
    check8("pre.gap2", 4'b0000, 2'd3, 1'b0, 1'b0);
    tick();
    check8("pre.owner0", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Reset mid-grant clears everything without an expired pulse.
    doReset();
    applyStimulus(4'b0010, 4'b0000);
    for (int c = 0; c < 5; c++) tick();
    check8("rst.before", 4'b0010, 2'd1, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    check8("rst.cleared", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(4'b0011, 4'b0000);
    tick();
    check8("rst.first", 4'b0001, 2'd0, 1'b1, 1'b0);

    // MAX_HOLD=1: a lone continuous requester alternates grant and expired gap.
    doReset();
    applyStimulus(4'b0000, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput($sformatf("mh1.grant%0d", k), bus1.grant, 4'b0001);
      checkOutput($sformatf("mh1.exp%0d", k), bus1.expired, 0);
      tick();
      checkOutput($sformatf("mh1.gap%0d", k), bus1.grant, 4'b0000);
      checkOutput($sformatf("mh1.gexp%0d", k), bus1.expired, 1);
    end

    // Random traffic: requests stay up until served; owners drop randomly or on expiry.
    doReset();
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (bus8.req[i] && !bus8.grant[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        checkOutput($sformatf("fair.r%0d", i), wait_cnt[i] <= 27, 1);
      end
      nreq = bus8.req;
      if (bus8.expired) nreq[bus8.grant_idx] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (bus8.grant[i]) begin
          if ($urandom_range(0, 5) == 0) nreq[i] = 1'b0;
        end else if (!bus8.req[i]) begin
          if ($urandom_range(0, 3) == 0) nreq[i] = 1'b1;
        end
      end
      applyStimulus(nreq, 4'($urandom_range(0, 15)));
    end

    applyStimulus(4'b0000, 4'b0000);
    tick();
    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
